imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of `if_stage`. It accepts a byte stream and assembles little-endian 32-bit instruction words. It writes them sequentially into the IF-stage instruction memory through the `i_wen`/`i_wdata` write port, plus a word address. It holds the whole pipeline in reset until the image is loaded, then releases the core.

## Interface
Parameters:
- `IM_ADDR_W`, default 10: instruction-memory word-address width; capacity is 2^IM_ADDR_W words.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_start` in 1: single-cycle load request.
- `i_word_count` in IM_ADDR_W+1: number of image words; sampled on the cycle `i_start` is accepted.
- `i_byte_valid` in 1: stream byte valid.
- `i_byte_data` in 8: stream byte.
- `o_byte_ready` out 1: loader accepts a byte; a transfer occurs when valid & ready.
- `o_wen` out 4: byte write enables to IF instruction memory; `4'hF` or `4'h0` only.
- `o_wdata` out 32: write data.
- `o_waddr` out IM_ADDR_W: word write address.
- `o_core_rst_n` out 1: active-low reset driven to all pipeline stages.
- `o_busy` out 1: high in LOAD/CHECK.
- `o_done` out 1: high in RUN.
- `o_error` out 1: high in ERROR.

## Operation
- States: IDLE, LOAD, CHECK (only with the macro), RUN, ERROR.
- Reset values: `o_wen`=0, `o_wdata`=0, `o_waddr`=0, `o_core_rst_n`=0, `o_byte_ready`=0, `o_busy`=0, `o_done`=0, `o_error`=0. The state is IDLE. Reset mid-load aborts immediately; partial writes are not undone.
- IDLE, RUN, ERROR + `i_start`:
  - count==0 or count>2^IM_ADDR_W -> ERROR.
  - Otherwise -> LOAD, with word counter = count, address = 0, byte index = 0, and `o_core_rst_n` = 0.
- `i_start` while in LOAD/CHECK is ignored.
- LOAD:
  - `o_byte_ready`=1.
  - Accepted byte k (k = 0..3 within a word) is placed in bits [8k+7:8k] of the assembly register.
  - On acceptance of byte 3, the next cycle drives `o_wen`=4'hF, `o_wdata`=word and `o_waddr`=address for exactly one cycle. The address then increments and the counter decrements.
  - Throughput is one byte per cycle; a byte may be accepted in the same cycle as a write pulse.
- After the final word's write pulse -> RUN (or CHECK when the macro is defined).
- RUN: `o_core_rst_n`=1, `o_done`=1, `o_byte_ready`=0. The stream is ignored.
- ERROR: `o_error`=1, `o_core_rst_n`=0, `o_byte_ready`=0. Only `i_start` or `rst_n` exits.
- Gaps in `i_byte_valid` stall assembly with no state loss.
- The address never wraps within a load because the count is range-checked.

## Timing
- Last byte of word accepted in cycle N -> `o_wen` high in cycle N+1.
- Final word (no checksum): write pulse in N+1, `o_core_rst_n`=1 and `o_done`=1 from cycle N+2.
- `i_start` accepted in cycle S -> `o_byte_ready`=1 and `o_busy`=1 from S+1.
- `i_start` in RUN drops `o_core_rst_n` to 0 in S+1.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - The loader keeps a running XOR of all written words.
  - After the last data word it enters CHECK, with `o_byte_ready`=1. It accepts 4 more bytes as a little-endian checksum word, which is never written to memory.
  - On the cycle after the 4th checksum byte: match -> RUN; mismatch -> ERROR.
  - The core is released at checksum-byte-3 acceptance + 2 cycles.
- Undefined: the CHECK state, XOR register and compare logic are absent; the loader goes to RUN directly after the final write.

## Test plan
- Reset for 3 cycles, then release: all outputs 0, state IDLE.
- Reset mid-load: assert `rst_n`=0 during a load -> next cycle all outputs return to reset values.
- Two-word load:
  - Stimulus: `i_word_count`=2, bytes 13 00 00 00 B3 05 B5 00, `i_byte_valid` held high.
  - Writes: `o_waddr`=0 with `o_wdata`=32'h00000013; `o_waddr`=1 with `o_wdata`=32'h00B505B3.
  - `o_core_rst_n` rises 2 cycles after the 8th byte.
- Range check:
  - `i_word_count`=0 -> `o_error`=1 the next cycle and no `o_wen` pulse.
  - `i_word_count`=2^IM_ADDR_W+1 -> `o_error`=1 the next cycle and no `o_wen` pulse.
- Irregular `i_byte_valid` with random gaps over 16 words -> same memory contents as the back-to-back case, with a write pulse per word.
- Restart: `i_start` in RUN with count=1 -> `o_core_rst_n` is 0 the next cycle; a single write lands at address 0; RUN is re-entered.
- Checksum (macro defined):
  - Two-word image above, checksum 32'h00B505A0 -> RUN.
  - Same image, checksum 32'h00000000 -> ERROR with `o_core_rst_n` held at 0.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream to IF instruction memory, holds core in reset until loaded
// Optional checksum phase enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IM_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [IM_ADDR_W:0]   i_word_count,
    input  logic                 i_byte_valid,
    input  logic [7:0]           i_byte_data,
    output logic                 o_byte_ready,
    output logic [3:0]           o_wen,
    output logic [31:0]          o_wdata,
    output logic [IM_ADDR_W-1:0] o_waddr,
    output logic                 o_core_rst_n,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd2;
`endif
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [IM_ADDR_W:0]   MAX_WORDS = {1'b1, {IM_ADDR_W{1'b0}}};
    localparam logic [IM_ADDR_W:0]   CNT_ONE   = {{IM_ADDR_W{1'b0}}, 1'b1};
    localparam logic [IM_ADDR_W-1:0] ADDR_ONE  = {{(IM_ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic [IM_ADDR_W:0]   cnt_q, cnt_d;
    logic [IM_ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]           idx_q, idx_d;
    logic [23:0]          asm_q, asm_d;
    logic [3:0]           wen_q, wen_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [IM_ADDR_W-1:0] waddr_q, waddr_d;
    logic                 ready_q, ready_d;
    logic                 core_rst_n_q, busy_q, done_q, error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]          xor_q, xor_d;
    logic                 chk_fin_q, chk_fin_d;
    logic                 chk_ok_q, chk_ok_d;
`endif

    logic        accept;
    logic [31:0] word;

    assign accept = i_byte_valid & ready_q;
    // Byte 3 is taken straight from the stream so the word is ready on its acceptance cycle.
    assign word   = {i_byte_data, asm_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        wen_d   = 4'h0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        ready_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d     = xor_q;
        chk_fin_d = 1'b0;
        chk_ok_d  = chk_ok_q;
`endif
        if (accept) begin
            case (idx_q)
                2'd0:    asm_d[7:0]   = i_byte_data;
                2'd1:    asm_d[15:8]  = i_byte_data;
                2'd2:    asm_d[23:16] = i_byte_data;
                default: asm_d        = asm_q;
            endcase
        end
        case (state_q)
            S_LOAD: begin
                if (cnt_q == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
                    ready_d = 1'b1;
`else
                    state_d = S_RUN;
`endif
                end else begin
                    ready_d = 1'b1;
                    if (accept) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            wen_d   = 4'hF;
                            wdata_d = word;
                            waddr_d = addr_q;
                            addr_d  = addr_q + ADDR_ONE;
                            cnt_d   = cnt_q - CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            xor_d   = xor_q ^ word;
`endif
                            // Stop accepting once the final word is captured.
                            if (cnt_q == CNT_ONE) ready_d = 1'b0;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (chk_fin_q) begin
                    state_d = chk_ok_q ? S_RUN : S_ERROR;
                end else begin
                    ready_d = 1'b1;
                    if (accept) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            chk_fin_d = 1'b1;
                            chk_ok_d  = (word == xor_q);
                            ready_d   = 1'b0;
                        end
                    end
                end
            end
`endif
            default: begin
                if (i_start) begin
                    if (i_word_count == '0 || i_word_count > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_LOAD;
                        cnt_d   = i_word_count;
                        addr_d  = '0;
                        idx_d   = 2'd0;
                        ready_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_d   = '0;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            idx_q        <= 2'd0;
            asm_q        <= '0;
            wen_q        <= 4'h0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            ready_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
            chk_fin_q    <= 1'b0;
            chk_ok_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            ready_q      <= ready_d;
            core_rst_n_q <= (state_d == S_RUN);
            busy_q       <= (state_d == S_LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                            || (state_d == S_CHECK)
`endif
                            ;
            done_q       <= (state_d == S_RUN);
            error_q      <= (state_d == S_ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
            chk_fin_q    <= chk_fin_d;
            chk_ok_q     <= chk_ok_d;
`endif
        end
    end

    assign o_byte_ready = ready_q;
    assign o_wen        = wen_q;
    assign o_wdata      = wdata_q;
    assign o_waddr      = waddr_q;
    assign o_core_rst_n = core_rst_n_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [AW:0]   i_word_count = '0;
    logic          i_byte_valid = 1'b0;
    logic [7:0]    i_byte_data = '0;
    logic          o_byte_ready;
    logic [3:0]    o_wen;
    logic [31:0]   o_wdata;
    logic [AW-1:0] o_waddr;
    logic          o_core_rst_n, o_busy, o_done, o_error;

    int tests = 0;
    int fails = 0;

    logic [AW+31:0] sb[$];
    logic [31:0]    img[0:15];
    logic [31:0]    got_mem[0:15];

    imem_loader #(.IM_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_word_count(i_word_count),
        .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data), .o_byte_ready(o_byte_ready),
        .o_wen(o_wen), .o_wdata(o_wdata), .o_waddr(o_waddr), .o_core_rst_n(o_core_rst_n),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && o_wen !== 4'h0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", o_waddr, o_wdata);
            end else begin
                logic [AW+31:0] e;
                e = sb.pop_front();
                if (o_wen !== 4'hF || {o_waddr, o_wdata} !== e) begin
                    fails++;
                    $display("FAIL write: got wen %h addr %h data %h expected wen f addr %h data %h",
                             o_wen, o_waddr, o_wdata, e[AW+31:32], e[31:0]);
                end
            end
            if (o_waddr < 16) got_mem[o_waddr[3:0]] = o_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int t;
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        if (g > 0) begin
            i_byte_valid = 1'b0;
            repeat (g) step();
        end
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (o_byte_ready) break;
            t++;
            if (t > 200) begin
                chk("byte_ready_timeout", 0, 1);
                break;
            end
        end
        step();
        i_byte_valid = 1'b0;
    endtask

    task automatic start_load(input logic [AW:0] n);
        i_start = 1'b1;
        i_word_count = n;
        step();
        i_start = 1'b0;
        chk("start_busy", o_busy, 1);
        chk("start_ready", o_byte_ready, 1);
        chk("start_core_rst", o_core_rst_n, 0);
        chk("start_done", o_done, 0);
    endtask

    task automatic send_words(input int n, input int max_gap);
        for (int w = 0; w < n; w++) begin
            sb.push_back({w[AW-1:0], img[w]});
            for (int k = 0; k < 4; k++) send_byte(img[w][8*k +: 8], max_gap);
        end
    endtask

    task automatic send_word_raw(input logic [31:0] v);
        for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], 0);
    endtask

    // Called right after the last stream byte is accepted.
    task automatic expect_release(input string tag);
        chk({tag, "_held"}, o_core_rst_n, 0);
        step();
        chk({tag, "_core_rst"}, o_core_rst_n, 1);
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_ready"}, o_byte_ready, 0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 0);
    endtask

    task automatic finish_load(input string tag, input int n);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [31:0] x;
        x = '0;
        for (int w = 0; w < n; w++) x ^= img[w];
        send_word_raw(x);
`else
        tests += 0 * n;
`endif
        expect_release(tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_outs"}, {o_wen, o_wdata, o_waddr, o_core_rst_n, o_byte_ready, o_busy, o_done, o_error}, '0);
    endtask

    initial begin
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        chk_reset_outputs("post_reset");

        // Two-word load, back-to-back bytes.
        img[0] = 32'h00000013;
        img[1] = 32'h00B505B3;
        start_load(2);
        send_words(2, 0);
        finish_load("two_word", 2);

        // Range checks from RUN and ERROR.
        start_range(0, "cnt0");
        start_range(11'd1025, "cnt1025");

        // Restart from ERROR/RUN with a single word.
        img[0] = 32'hDEADBEEF;
        start_load(1);
        send_words(1, 0);
        finish_load("single", 1);
        i_start = 1'b1;
        i_word_count = 1;
        step();
        i_start = 1'b0;
        chk("restart_core_rst", o_core_rst_n, 0);
        chk("restart_done", o_done, 0);
        img[0] = 32'hCAFE0001;
        send_words(1, 0);
        finish_load("restart", 1);

        // 16 words back-to-back, then the same image with random gaps.
        for (int i = 0; i < 16; i++) img[i] = 32'h11223344 ^ (32'(i) * 32'h01030507);
        start_load(16);
        send_words(16, 0);
        finish_load("b2b16", 16);
        for (int i = 0; i < 16; i++) got_mem[i] = '0;
        start_load(16);
        send_words(16, 3);
        finish_load("gap16", 16);
        for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), got_mem[i], img[i]);

        // Reset mid-load after one full word and one extra byte.
        start_load(2);
        sb.push_back({10'd0, img[0]});
        for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
        send_byte(8'h5A, 0);
        rst_n = 1'b0;
        step();
        chk_reset_outputs("midload_reset");
        chk("midload_sb_empty", 64'(sb.size()), 0);
        rst_n = 1'b1;
        step();
        chk_reset_outputs("midload_idle");

`ifdef IMEM_LOADER_CHECKSUM_EN
        img[0] = 32'h00000013;
        img[1] = 32'h00B505B3;
        start_load(2);
        send_words(2, 0);
        chk("cks_state_busy", o_busy, 1);
        send_word_raw(32'h00B505A0);
        expect_release("cks_ok");
        start_load(2);
        send_words(2, 0);
        send_word_raw(32'h00000000);
        chk("cks_bad_held", o_core_rst_n, 0);
        step();
        chk("cks_bad_error", o_error, 1);
        chk("cks_bad_core_rst", o_core_rst_n, 0);
        step();
        chk("cks_bad_error_hold", o_error, 1);
`endif

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic start_range(input logic [AW:0] n, input string tag);
        i_start = 1'b1;
        i_word_count = n;
        step();
        i_start = 1'b0;
        chk({tag, "_error"}, o_error, 1);
        chk({tag, "_core_rst"}, o_core_rst_n, 0);
        chk({tag, "_ready"}, o_byte_ready, 0);
        i_byte_valid = 1'b1;
        i_byte_data = 8'hEE;
        repeat (6) step();
        i_byte_valid = 1'b0;
        chk({tag, "_error_hold"}, o_error, 1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 0);
    endtask

endmodule
